core_fetch_ctrl: RTL
====================

// Module: core_fetch_ctrl
// PURPOSE
//  Fetch controller sequencing instruction ROM for the RV32I core: owns the PC, issues
//  ROM reads over a req/ack handshake (variable latency) and buffers fetched words in a
//  small FIFO. The FIFO feeds the IF/ID boundary. Handles EX-stage jump redirects
//  (flush plus discard of in-flight read) and pipeline hold backpressure.
// PARAMETERS
//  RESET_ADDR  32'h0000_0000  PC value after reset; word aligned
//  FIFO_DEPTH  2              fetch buffer entries; power of 2, >=2
//  NOP_INST    32'h0000_0013  inst_out value when buffer empty (addi x0,x0,0)
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous reset, active-high
//  jump_flag_in    in   1   redirect request from EX (single-cycle pulse)
//  jump_addr_in    in   32  redirect target
//  hold_flag_in    in   1   IF/ID cannot accept; head entry held
//  rom_req_out     out  1   ROM read request; registered
//  rom_addr_out    out  32  ROM read address; registered, stable while req high
//  rom_ack_in      in   1   1-cycle read-complete strobe; data valid same cycle
//  rom_data_in     in   32  ROM read data
//  pc_addr_out     out  32  next address to be requested
//  inst_valid_out  out  1   buffer head valid (FIFO not empty)
//  inst_out        out  32  head instruction, NOP_INST when empty
//  inst_addr_out   out  32  head instruction address, 0 when empty
// BEHAVIOUR
//  Reset: state IDLE, pc=RESET_ADDR, rom_req_out=0, rom_addr_out=RESET_ADDR,
//   FIFO empty -> inst_valid_out=0, inst_out=NOP_INST, inst_addr_out=0.
//  Pop = inst_valid_out & !hold_flag_in & !jump_flag_in. Push on accepted ack only.
//  cnt_nxt = count + push - pop. credit = cnt_nxt < FIFO_DEPTH.
//  At most one ROM read outstanding. rom_req_out = (state != IDLE).
//  Issue = rom_addr_out<=pc, pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
//  Jump: flushes FIFO (count<=0) at that edge; pc<=jump_addr_in & ~32'h3. Jump beats
//   pop, push and issue.
//  States:
//   IDLE : jump -> redirect, stay IDLE; else credit -> issue, go REQ.
//   REQ  : ack & jump  -> discard data, redirect, go IDLE.
//          ack & !jump -> push {rom_addr_out, rom_data_in}; credit -> issue, stay REQ
//                         (back-to-back); else go IDLE.
//          !ack & jump -> redirect, go DRAIN (read still owed).
//          !ack        -> hold req/addr, stay REQ.
//   DRAIN: req/addr held; ack -> discard data, go IDLE; jump updates pc (newest wins)
//          with or without ack.
//  rom_ack_in while rom_req_out=0 ignored (bench asserts never occurs).
//  Latency: zero-wait ROM -> req visible 1 cycle after rst release, first
//   inst_valid_out 1 cycle later; steady 1 inst/cycle while hold low.
//  Hold: head entry, inst_out, inst_addr_out stable; FIFO fills to FIFO_DEPTH then
//   requests stop; no loss, duplication or reorder on release.
//  rst mid-read: all state to reset values next edge; the in-flight ack that follows
//   is ignored (req low) or, if req already re-issued, matched to new request; ROM
//   also sees rst and drops pending reads.
// STRUCTURE
//  Shared core/defines.v: `InstAddressBus, `InstByteBus, `ZeroWord, `INST_NOP,
//   fetch-state encodings (IDLE/REQ/DRAIN).
//  Sub-module core_fetch_fifo: sync FIFO, width 64 {addr,inst}, depth FIFO_DEPTH,
//   push/pop/flush, count, head out; flush beats push.
//  Top: 3-state FSM, pc reg, credit logic, output muxing to NOP/0 when empty.
// TESTING
//  1 Reset, zero-wait ROM data=addr, hold=0 -> req addr 0 cycle 1; inst_addr_out
//    0,4,8,C on consecutive cycles from cycle 2, inst_out matches.
//  2 hold=1 for 5 cycles while head=0x8 -> head stays 0x8, req stops after FIFO full;
//    release -> 0x8,0xC,0x10 in order, no gap or dup.
//  3 3-cycle ROM, jump 0x100 pulse while 0x10 outstanding -> valid 0 next cycle, DRAIN
//    until ack, 0x10 data never presented, next rom_addr_out 0x100.
//  4 jump 0x200 same cycle as ack -> data discarded, next issued addr 0x200.
//  5 jump to 0x102 -> fetch at 0x100; RESET_ADDR=32'hFFFF_FFFC -> second fetch at 0x0.
//  6 rst high 1 cycle during REQ -> next cycle req 0, valid 0, pc=RESET_ADDR; fetch
//    restarts at RESET_ADDR.

Source files
------------

// File: rtl/core_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Fetch-state encodings, FIFO entry layout and the word-align helper.
package core_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
   localparam logic [31:0] INST_NOP  = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] a);
      return a & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// Synchronous fetch buffer of {addr,inst} entries; flush beats push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module core_fetch_fifo
   import core_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  fetch_entry_t               wr_entry,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // storage needs no reset: head is qualified by count in the top
   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem[wr_ptr] <= wr_entry;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/core_fetch_ctrl.sv
// Fetch controller: owns the PC, issues one ROM read at a time over req/ack
// and buffers returned words for the IF/ID boundary; handles jumps and hold.
//
// state | meaning
// IDLE  | no read outstanding; issue when the buffer has credit
// REQ   | read outstanding; ack pushes data and may issue back-to-back
// DRAIN | read outstanding after a jump; its data is discarded on ack
module core_fetch_ctrl
   import core_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INST   = INST_NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_in,
   input  logic [31:0] jump_addr_in,
   input  logic        hold_flag_in,
   output logic        rom_req_out,
   output logic [31:0] rom_addr_out,
   input  logic        rom_ack_in,
   input  logic [31:0] rom_data_in,
   output logic [31:0] pc_addr_out,
   output logic        inst_valid_out,
   output logic [31:0] inst_out,
   output logic [31:0] inst_addr_out
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t  state, state_nxt;
   logic [31:0]   pc, pc_nxt;
   logic [31:0]   addr_nxt;
   logic          issue;
   logic          push, pop, credit;
   logic [CW-1:0] count, cnt_nxt;
   fetch_entry_t  head;
   fetch_entry_t  wr_entry;

   assign pop      = inst_valid_out && !hold_flag_in && !jump_flag_in;
   assign push     = (state == ST_REQ) && rom_ack_in && !jump_flag_in;
   assign cnt_nxt  = count + CW'(push) - CW'(pop);
   assign credit   = cnt_nxt < CW'(FIFO_DEPTH);
   assign wr_entry = '{addr: rom_addr_out, inst: rom_data_in};

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         pc           <= RESET_ADDR;
         rom_addr_out <= RESET_ADDR;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         rom_addr_out <= addr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      addr_nxt  = rom_addr_out;
      issue     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!jump_flag_in && credit) begin
               issue     = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (rom_ack_in) begin
               if (jump_flag_in)  state_nxt = ST_IDLE;
               else if (credit)   issue     = 1'b1;
               else               state_nxt = ST_IDLE;
            end else if (jump_flag_in) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (rom_ack_in) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (issue) begin
         addr_nxt = pc;
         pc_nxt   = pc + 32'd4;
      end
      // a redirect overrides any increment, including while draining
      if (jump_flag_in) pc_nxt = align_word(jump_addr_in);
   end

   core_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .flush    (jump_flag_in),
      .wr_entry (wr_entry),
      .head     (head),
      .count    (count)
   );

   assign rom_req_out    = (state != ST_IDLE);
   assign pc_addr_out    = pc;
   assign inst_valid_out = (count != '0);
   assign inst_out       = inst_valid_out ? head.inst : NOP_INST;
   assign inst_addr_out  = inst_valid_out ? head.addr : ZERO_WORD;

endmodule
